// File: rtl/tile_raster_walker.sv
// Walks one 32x32 tile in raster order. Three edge planes are stepped incrementally
// for coverage and the invW plane is interpolated for depth, all feeding the z-buffer.
module tile_raster_walker #(
    parameter int EW = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [5:0]           tile_x,
    input  logic [5:0]           tile_y,
    input  logic signed [EW-1:0] e0_a,
    input  logic signed [EW-1:0] e0_b,
    input  logic signed [EW-1:0] e0_c,
    input  logic signed [EW-1:0] e1_a,
    input  logic signed [EW-1:0] e1_b,
    input  logic signed [EW-1:0] e1_c,
    input  logic signed [EW-1:0] e2_a,
    input  logic signed [EW-1:0] e2_b,
    input  logic signed [EW-1:0] e2_c,
    input  logic signed [EW-1:0] invw_a,
    input  logic signed [EW-1:0] invw_b,
    input  logic signed [EW-1:0] invw_c,
    input  logic                 stall,
    output logic                 busy,
    output logic                 done,
    output logic                 pix_valid,
    output logic [9:0]           z_buff_addr,
    output logic [EW-1:0]        z_in,
    output logic                 inTriangle
);
    // Planes 0..2 are the triangle edges, plane 3 is invW.
    localparam int NP = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_WALK, ST_DONE} state_t;

    state_t state_q, state_d;

    logic signed [EW-1:0] a_in   [NP];
    logic signed [EW-1:0] b_in   [NP];
    logic signed [EW-1:0] c_in   [NP];
    logic signed [EW-1:0] a_q    [NP];
    logic signed [EW-1:0] b_q    [NP];
    logic signed [EW-1:0] c_q    [NP];
    logic signed [EW-1:0] origin [NP];
    logic signed [EW-1:0] row_q  [NP];
    logic signed [EW-1:0] row_d  [NP];
    logic signed [EW-1:0] pix_q  [NP];
    logic signed [EW-1:0] pix_d  [NP];

    logic [5:0]           tx_q, ty_q;
    logic signed [EW-1:0] ox, oy;
    logic [4:0]           x_q, y_q, x_d, y_d;
    logic                 busy_d, done_d, valid_d, cov_d;
    logic                 accept;

    assign accept = (state_q == ST_IDLE) && start;

    always_comb begin
        a_in[0] = e0_a;   b_in[0] = e0_b;   c_in[0] = e0_c;
        a_in[1] = e1_a;   b_in[1] = e1_b;   c_in[1] = e1_c;
        a_in[2] = e2_a;   b_in[2] = e2_b;   c_in[2] = e2_c;
        a_in[3] = invw_a; b_in[3] = invw_b; c_in[3] = invw_c;
    end

    // NOTE: the coefficient latches are deliberately not reset; they are always
    // rewritten by an accepted start before anything reads them.
    always_ff @(posedge clock) begin
        if (accept) begin
            tx_q <= tile_x;
            ty_q <= tile_y;
            for (int i = 0; i < NP; i++) begin
                a_q[i] <= a_in[i];
                b_q[i] <= b_in[i];
                c_q[i] <= c_in[i];
            end
        end
    end

    // Tile origin in screen pixels; products wrap to EW bits.
    assign ox = {{(EW-11){1'b0}}, tx_q, 5'd0};
    assign oy = {{(EW-11){1'b0}}, ty_q, 5'd0};

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            origin[i] = a_q[i] * ox + b_q[i] * oy + c_q[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every value written here gets a default first so no latch is inferred;
    // combinational logic uses blocking '=', the registers below use '<='.
    always_comb begin
        state_d = state_q;
        busy_d  = busy;
        done_d  = 1'b0;
        valid_d = pix_valid;
        x_d     = x_q;
        y_d     = y_q;
        for (int i = 0; i < NP; i++) begin
            row_d[i] = row_q[i];
            pix_d[i] = pix_q[i];
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SETUP;
                    busy_d  = 1'b1;
                end
            end
            ST_SETUP: begin
                for (int i = 0; i < NP; i++) begin
                    row_d[i] = origin[i];
                    pix_d[i] = origin[i];
                end
                x_d     = 5'd0;
                y_d     = 5'd0;
                valid_d = 1'b1;
                state_d = ST_WALK;
            end
            ST_WALK: begin
                if (!stall) begin
                    if (x_q != 5'd31) begin
                        for (int i = 0; i < NP; i++) begin
                            pix_d[i] = pix_q[i] + a_q[i];
                        end
                        x_d = x_q + 5'd1;
                    end else if (y_q != 5'd31) begin
                        // Row wrap: step the row value and restart the pixel stepper from it.
                        for (int i = 0; i < NP; i++) begin
                            row_d[i] = row_q[i] + b_q[i];
                            pix_d[i] = row_q[i] + b_q[i];
                        end
                        x_d = 5'd0;
                        y_d = y_q + 5'd1;
                    end else begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Coverage is registered from next-cycle values so inTriangle is a flop output.
        cov_d = valid_d && !pix_d[0][EW-1] && !pix_d[1][EW-1] && !pix_d[2][EW-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            pix_valid  <= 1'b0;
            inTriangle <= 1'b0;
            x_q        <= 5'd0;
            y_q        <= 5'd0;
            for (int i = 0; i < NP; i++) begin
                row_q[i] <= '0;
                pix_q[i] <= '0;
            end
        end else begin
            busy       <= busy_d;
            done       <= done_d;
            pix_valid  <= valid_d;
            inTriangle <= cov_d;
            x_q        <= x_d;
            y_q        <= y_d;
            for (int i = 0; i < NP; i++) begin
                row_q[i] <= row_d[i];
                pix_q[i] <= pix_d[i];
            end
        end
    end

    assign z_buff_addr = {y_q, x_q};
    assign z_in        = pix_q[NP-1];

endmodule

// File: tb/tb_tile_raster_walker.sv
// Directed bench for tile_raster_walker: expected pixels come from evaluating the
// plane equations directly in screen coordinates.
module tb_tile_raster_walker;
    localparam int EW = 32;

    logic                 clock = 1'b0;
    logic                 reset, start, stall;
    logic [5:0]           tile_x, tile_y;
    logic signed [EW-1:0] e0_a, e0_b, e0_c, e1_a, e1_b, e1_c, e2_a, e2_b, e2_c;
    logic signed [EW-1:0] invw_a, invw_b, invw_c;
    logic                 busy, done, pix_valid, inTriangle;
    logic [9:0]           z_buff_addr;
    logic [EW-1:0]        z_in;

    int checks = 0;
    int errors = 0;
    int cyc;
    int m_tx, m_ty;
    int m_a [3:0];
    int m_b [3:0];
    int m_c [3:0];

    always #5 clock = ~clock;

    tile_raster_walker #(.EW(EW)) dut (
        .clock(clock), .reset(reset), .start(start),
        .tile_x(tile_x), .tile_y(tile_y),
        .e0_a(e0_a), .e0_b(e0_b), .e0_c(e0_c),
        .e1_a(e1_a), .e1_b(e1_b), .e1_c(e1_c),
        .e2_a(e2_a), .e2_b(e2_b), .e2_c(e2_c),
        .invw_a(invw_a), .invw_b(invw_b), .invw_c(invw_c),
        .stall(stall), .busy(busy), .done(done), .pix_valid(pix_valid),
        .z_buff_addr(z_buff_addr), .z_in(z_in), .inTriangle(inTriangle)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic set_inputs(input int tx, input int ty,
                              input int a0, input int b0, input int c0,
                              input int a1, input int b1, input int c1,
                              input int a2, input int b2, input int c2,
                              input int wa, input int wb, input int wc);
        tile_x = 6'(tx); tile_y = 6'(ty);
        e0_a = a0; e0_b = b0; e0_c = c0;
        e1_a = a1; e1_b = b1; e1_c = c1;
        e2_a = a2; e2_b = b2; e2_c = c2;
        invw_a = wa; invw_b = wb; invw_c = wc;
    endtask

    task automatic latch_model();
        m_tx = int'(tile_x); m_ty = int'(tile_y);
        m_a[0] = e0_a;   m_b[0] = e0_b;   m_c[0] = e0_c;
        m_a[1] = e1_a;   m_b[1] = e1_b;   m_c[1] = e1_c;
        m_a[2] = e2_a;   m_b[2] = e2_b;   m_c[2] = e2_c;
        m_a[3] = invw_a; m_b[3] = invw_b; m_c[3] = invw_c;
    endtask

    // Drives start for one edge at cycle 0 and checks the SETUP cycle.
    task automatic pulse_start(input string tag);
        latch_model();
        start = 1'b1;
        cyc   = 0;
        @(negedge clock);
        cyc++;
        start = 1'b0;
        check({tag, "_setup_busy"}, 32'(busy), 32'd1);
        check({tag, "_setup_valid"}, 32'(pix_valid), 32'd0);
        @(negedge clock);
        cyc++;
    endtask

    task automatic walk(input string tag,
                        input int sa0, input int sn0, input int sa1, input int sn1,
                        input int start_at, input int reset_at,
                        input int exp_cov, input int z0, input bit zeq);
        int x, y, gx, gy, ns, cov, ez;
        bit ecov;
        int stalls;
        cov    = 0;
        stalls = 0;
        for (int p = 0; p < 1024; p++) begin
            x  = p % 32;
            y  = p / 32;
            gx = m_tx * 32 + x;
            gy = m_ty * 32 + y;
            ecov = 1'b1;
            for (int i = 0; i < 3; i++) begin
                if (m_a[i] * gx + m_b[i] * gy + m_c[i] < 0) ecov = 1'b0;
            end
            ez = m_a[3] * gx + m_b[3] * gy + m_c[3];
            if (ecov) cov++;
            ns = (p == sa0) ? sn0 : (p == sa1) ? sn1 : 0;
            stalls += ns;
            if (p == 0) check({tag, "_z_origin"}, z_in, 32'(z0));
            for (int k = 0; k <= ns; k++) begin
                check({tag, "_valid"}, 32'(pix_valid), 32'd1);
                check({tag, "_addr"}, 32'(z_buff_addr), 32'(p));
                check({tag, "_z"}, z_in, 32'(ez));
                check({tag, "_cov"}, 32'(inTriangle), 32'(ecov));
                if (zeq) check({tag, "_z_eq_addr"}, z_in, 32'(z_buff_addr));
                if (p == reset_at) begin
                    reset = 1'b1;
                    @(negedge clock);
                    cyc++;
                    reset = 1'b0;
                    check({tag, "_rst_busy"}, 32'(busy), 32'd0);
                    check({tag, "_rst_done"}, 32'(done), 32'd0);
                    check({tag, "_rst_valid"}, 32'(pix_valid), 32'd0);
                    check({tag, "_rst_cov"}, 32'(inTriangle), 32'd0);
                    check({tag, "_rst_addr"}, 32'(z_buff_addr), 32'd0);
                    check({tag, "_rst_z"}, z_in, 32'd0);
                    for (int j = 0; j < 3; j++) begin
                        @(negedge clock);
                        cyc++;
                        check({tag, "_rst_no_done"}, 32'(done), 32'd0);
                        check({tag, "_rst_idle"}, 32'(busy), 32'd0);
                    end
                    return;
                end
                stall = (k < ns);
                if (p == start_at && k == 0) begin
                    set_inputs(5, 5, 0, 0, -1, 0, 0, -1, 0, 0, -1, 9, 9, 9);
                    start = 1'b1;
                end
                @(negedge clock);
                cyc++;
                start = 1'b0;
                stall = 1'b0;
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_done_cov"}, 32'(inTriangle), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        check({tag, "_done_cycle"}, 32'(cyc), 32'(1026 + stalls));
        check({tag, "_cov_count"}, 32'(cov), 32'(exp_cov));
        @(negedge clock);
        cyc++;
        check({tag, "_idle_done"}, 32'(done), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        cyc   = 0;
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        set_inputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_valid", 32'(pix_valid), 32'd0);
        check("reset_cov", 32'(inTriangle), 32'd0);
        check("reset_addr", 32'(z_buff_addr), 32'd0);
        check("reset_z", z_in, 32'd0);
        reset = 1'b0;
        stall = 1'b1;
        @(negedge clock);
        check("idle_stall_busy", 32'(busy), 32'd0);
        stall = 1'b0;

        // Full cover: invW plane reproduces the tile-local address.
        set_inputs(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 32, 0);
        pulse_start("full");
        walk("full", -1, 0, -1, 0, -1, -1, 1024, 0, 1'b1);

        // Half plane: x_local 0..15 covered in every row.
        set_inputs(0, 0, -1, 0, 15, 0, 0, 1, 0, 0, 1, 2, -3, 100);
        pulse_start("half");
        walk("half", -1, 0, -1, 0, -1, -1, 512, 100, 1'b0);

        // Tile offset (1,2): covered for x_local>=8, y_local>=6; z origin 3*32+5*64+7.
        set_inputs(1, 2, 1, 0, -40, 0, 1, -70, 0, 0, 1, 3, 5, 7);
        pulse_start("offset");
        walk("offset", -1, 0, -1, 0, -1, -1, 624, 423, 1'b0);

        // Stall 3 cycles at address 5 and 1 cycle at the first row wrap.
        set_inputs(0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 32, 0);
        pulse_start("stall");
        walk("stall", 5, 3, 31, 1, -1, -1, 1024, 0, 1'b1);

        // A start with different coefficients at address 100 is ignored.
        set_inputs(1, 2, 1, 0, -40, 0, 1, -70, 0, 0, 1, 3, 5, 7);
        pulse_start("restart");
        walk("restart", -1, 0, -1, 0, 100, -1, 624, 423, 1'b0);

        // Reset at address 500 aborts with no done pulse.
        set_inputs(0, 0, -1, 0, 15, 0, 0, 1, 0, 0, 1, 2, -3, 100);
        pulse_start("abort");
        walk("abort", -1, 0, -1, 0, -1, 500, 0, 100, 1'b0);

        // Fresh tile (2,1) after the abort: z origin 64 + 32*32.
        set_inputs(2, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 32, 0);
        pulse_start("fresh");
        walk("fresh", -1, 0, -1, 0, -1, -1, 1024, 1088, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_raster_walker.md
# tile_raster_walker

Per-tile pixel walker and plane-equation interpolator that feeds the PVR depth stage. For one triangle it walks every pixel of a 32x32 tile in raster order, one pixel per unstalled cycle. It evaluates three edge functions incrementally to produce coverage, and interpolates the invW plane to produce the per-pixel depth value. Its outputs drive the z-buffer's `z_buff_addr`, `z_in` and `inTriangle` inputs directly.

## Interface

Parameters:
- `EW`, 32: width of edge and invW coefficients and accumulators (signed, two's complement).

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches all coefficient inputs and begins a tile walk. Ignored unless idle.
- `tile_x`, `tile_y`  in  6 each  tile index; pixel origin is (tile_x*32, tile_y*32).
- `e0_a`, `e0_b`, `e0_c`, `e1_a`, `e1_b`, `e1_c`, `e2_a`, `e2_b`, `e2_c`  in  EW each  edge coefficients; E(x,y) = a*x + b*y + c in screen pixels.
- `invw_a`, `invw_b`, `invw_c`  in  EW each  invW plane coefficients, same form.
- `stall`  in  1  downstream cannot accept (e.g. z-buffer clear in progress).
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last pixel is consumed.
- `pix_valid`  out  1  current output pixel is valid.
- `z_buff_addr`  out  10  tile-local address, y_local*32 + x_local.
- `z_in`  out  EW  interpolated invW for the current pixel.
- `inTriangle`  out  1  coverage of the current pixel; forced 0 when `pix_valid`=0.

## Operation

- States are IDLE, SETUP, WALK and DONE.
- **IDLE**
  - `start`=1 latches all coefficients and the tile index, then goes to SETUP.
- **SETUP** (exactly 1 cycle)
  - For each of the 4 planes, compute the origin value P0 = a*(tile_x<<5) + b*(tile_y<<5) + c.
  - Load each row accumulator and each pixel accumulator with P0.
  - Set x_local = y_local = 0, then go to WALK.
- **WALK**
  - Registered outputs present the pixel at (x_local, y_local).
  - A pixel is consumed on any cycle with `pix_valid`=1 and `stall`=0.
  - On consume with x_local<31: pixel accumulators += a, x_local++.
  - On consume with x_local==31 and y_local<31: row accumulators += b, pixel accumulators load the new row value, x_local=0, y_local++.
  - On consume at address 1023, go to DONE.
- **DONE**
  - `done`=1 and `pix_valid`=0 for one cycle, then go to IDLE.
- Coverage: `inTriangle` = `pix_valid` & (E0>=0) & (E1>=0) & (E2>=0), with signed compares. Zero counts as inside; there is no top-left rule.
- `z_in` is the invW pixel accumulator output as-is.
- All accumulators wrap modulo 2^EW. Products in SETUP are truncated to EW bits. Software guarantees no overflow across the tile.
- Reset values:
  - `busy`, `done`, `pix_valid` and `inTriangle` are 0.
  - `z_buff_addr` and `z_in` are 0.
  - State is IDLE.
- `start` during SETUP, WALK or DONE is ignored. Latched coefficients are not disturbed.
- `reset` mid-walk aborts immediately and returns to IDLE without a `done` pulse.
- `stall` during IDLE, SETUP or DONE has no effect.

## Timing

- `start` sampled at cycle 0; SETUP at cycle 1; first `pix_valid` with address 0 at cycle 2.
- With `stall` held low, addresses 0..1023 appear on cycles 2..1025, one per cycle with no bubble at row wrap. `done` pulses at cycle 1026, and a new `start` is accepted at cycle 1027.
- While `stall`=1 in WALK, `pix_valid`, `z_buff_addr`, `z_in` and `inTriangle` hold stable and no accumulator advances. Each stalled cycle delays `done` by one cycle.
- `busy` is high on cycles 1..1026 inclusive, and falls together with the return to IDLE.
- Every output is a flop output; there is no combinational path from `stall` or `start` to any output.

## Test plan

- Full cover: tile (0,0), all edges a=b=0 and c=1, invW a=1, b=32, c=0, no stall.
  - Required: 1024 valid pixels on cycles 2..1025, `inTriangle`=1 throughout, `z_in`==`z_buff_addr` each cycle, `done` at cycle 1026.
- Half plane: e0 a=-1, b=0, c=15; e1 and e2 have c=1.
  - Required: `inTriangle`=1 exactly for x_local 0..15 in every row, which gives 512 covered pixels.
- Tile offset: tile_x=1, tile_y=2; e0 a=1, c=-40; e1 b=1, c=-70; e2 c=1.
  - Required: coverage for x_local>=8 and y_local>=6.
  - Required: the `z_in` origin value equals invw_a*32 + invw_b*64 + invw_c.
- Stall: assert `stall` for 3 cycles while address 5 is presented, and again for 1 cycle at address 31 (row wrap).
  - Required: outputs frozen at those addresses, no address skipped or repeated after release, `done` delayed by 4 cycles.
- Start during walk: pulse `start` at address 100 with different coefficients.
  - Required: ignored; the walk completes with the original coefficients.
- Reset mid-walk: assert `reset` for 1 cycle at address 500.
  - Required: all outputs 0 the next cycle, no `done`; a subsequent `start` walks a fresh tile from address 0.
